// File: rtl/div_pkg.sv
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared widths, FSM state encoding and constants for div16_8_seq.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int REM_W      = 8;
    localparam int CNT_W      = 4;

    localparam logic [DIVIDEND_W-1:0] ZERO_DIV_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div16_8_seq_if.sv
// ============================================================================
//  Module   : div16_8_seq_if
//  Purpose  : Operand/result valid-ready bundle for the sequential divider.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface div16_8_seq_if;
    import div_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quot;
    logic [REM_W-1:0]      rem;
    logic                  div_zero;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, rem, div_zero
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, rem, div_zero
    );

endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division iteration (shift, compare,
//             conditional subtract).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_step
    import div_pkg::*;
(
    input  wire logic [REM_W:0]       r_in,
    input  wire logic                 q_msb,
    input  wire logic [DIVISOR_W-1:0] d,
    output logic      [REM_W:0]       r_out,
    output logic                      q_bit
);

    logic [REM_W:0] t;
    logic           unused_r_msb;

    // The partial remainder is always below the divisor, so its top bit is zero
    // and is dropped by the shift.
    assign unused_r_msb = r_in[REM_W];
    assign t            = {r_in[REM_W-1:0], q_msb};
    assign q_bit        = (t >= {1'b0, d});
    assign r_out        = q_bit ? (t - {1'b0, d}) : t;

endmodule

`default_nettype wire

// File: rtl/div16_8_seq.sv
// ============================================================================
//  Module   : div16_8_seq
//  Purpose  : Sequential radix-2 restoring divider, 16-bit / 8-bit, with
//             valid/ready handshakes and one operation in flight.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div16_8_seq
    import div_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    div16_8_seq_if.slave   bus
);

    state_t                state;
    state_t                state_nxt;
    logic [DIVIDEND_W-1:0] q_work;
    logic [REM_W:0]        r_work;
    logic [DIVISOR_W-1:0]  d_reg;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] quot_reg;
    logic [REM_W-1:0]      rem_reg;
    logic                  div_zero_reg;

    logic [REM_W:0]        step_r;
    logic                  step_q;
    logic                  accept;
    logic                  last_iter;

    div_step u_step (
        .r_in  (r_work),
        .q_msb (q_work[DIVIDEND_W-1]),
        .d     (d_reg),
        .r_out (step_r),
        .q_bit (step_q)
    );

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_iter = (cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers only change on DONE entry, so they hold the last result
    // through IDLE and the next RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_work       <= '0;
            r_work       <= '0;
            d_reg        <= '0;
            cnt          <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            div_zero_reg <= 1'b0;
        end else if (accept) begin
            q_work <= bus.dividend;
            d_reg  <= bus.divisor;
            r_work <= '0;
            cnt    <= '0;
            if (bus.divisor == '0) begin
                quot_reg     <= ZERO_DIV_QUOT;
                rem_reg      <= bus.dividend[REM_W-1:0];
                div_zero_reg <= 1'b1;
            end
        end else if (state == RUN) begin
            q_work <= {q_work[DIVIDEND_W-2:0], step_q};
            r_work <= step_r;
            cnt    <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_iter) begin
                quot_reg     <= {q_work[DIVIDEND_W-2:0], step_q};
                rem_reg      <= step_r[REM_W-1:0];
                div_zero_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quot      = quot_reg;
    assign bus.rem       = rem_reg;
    assign bus.div_zero  = div_zero_reg;

endmodule

`default_nettype wire
